mac_dot_seq: RTL and testbench

Dot-product sequencer sitting directly upstream of the MAC block. It accepts a command of length N, initial value and packing mode, then streams N operand beats into the MAC with accumulation enabled. After the MAC pipeline drains, it captures the accumulated result and returns it on a valid/ready result port. It owns all MAC control: enable, clear, config word and operand lanes.

---
 rtl/mac_dot_seq.sv | 140 ++++++++++++++
 tb/tb_mac_dot_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: takes a length/mode/init command, streams operand beats into
// the MAC with accumulation, waits for the MAC pipeline to drain and returns the result.
module mac_dot_seq #(
    parameter int W       = 8,
    parameter int ACC_W   = 32,
    parameter int CONF_W  = 3,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [1:0]              cmd_mode,
    input  logic [ACC_W-1:0]        cmd_init,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*W-1:0]          in_a,
    input  logic [W-1:0]            in_b,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [W-1:0]            mac_a0,
    output logic [W-1:0]            mac_a1,
    output logic [W-1:0]            mac_a2,
    output logic [W-1:0]            mac_a3,
    output logic [W-1:0]            mac_b0,
    output logic [ACC_W+CONF_W-1:0] mac_cfg,
    input  logic [ACC_W-1:0]        mac_c,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    busy
);

    localparam int DR_W = $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] beat_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic [1:0]       mode_q;
    logic [ACC_W-1:0] init_q;
    logic [CONF_W-1:0] conf_bits;

    // Lanes outside the active packing mode are forced to zero; mode 3 zeroes everything.
    function automatic logic [W-1:0] lane_mask(input logic [1:0] mode, input int lane,
                                               input logic [W-1:0] v);
        logic use_lane;
        case (mode)
            2'd0:    use_lane = (lane == 0);
            2'd1:    use_lane = (lane < 2);
            2'd2:    use_lane = 1'b1;
            default: use_lane = 1'b0;
        endcase
        return use_lane ? v : '0;
    endfunction

    always_comb begin
        conf_bits              = '0;
        conf_bits[1:0]         = mode_q;
        conf_bits[CONF_W-1]    = 1'b1;
    end

    assign cmd_ready = (state == IDLE);
    assign in_ready  = (state == RUN);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign mac_cfg   = (state != IDLE) ? {init_q, conf_bits} : '0;

    // Command fields are only observed while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            mode_q <= cmd_mode;
            init_q <= cmd_init;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_a0    <= '0;
            mac_a1    <= '0;
            mac_a2    <= '0;
            mac_a3    <= '0;
            mac_b0    <= '0;
            res_data  <= '0;
        end else begin
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beat_cnt <= cmd_len;
                        if (cmd_len == '0) begin
                            res_data <= cmd_init;
                            state    <= DONE;
                        end else begin
                            mac_clr <= 1'b1;
                            state   <= PRIME;
                        end
                    end
                end
                PRIME: state <= RUN;
                RUN: begin
                    if (in_valid) begin
                        mac_a0   <= lane_mask(mode_q, 0, in_a[W-1:0]);
                        mac_a1   <= lane_mask(mode_q, 1, in_a[2*W-1:W]);
                        mac_a2   <= lane_mask(mode_q, 2, in_a[3*W-1:2*W]);
                        mac_a3   <= lane_mask(mode_q, 3, in_a[4*W-1:3*W]);
                        mac_b0   <= in_b;
                        mac_en   <= 1'b1;
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == LEN_W'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                // The final enable cycle plus MAC_LAT pipeline cycles before mac_c settles.
                DRAIN: begin
                    if (drain_cnt == DR_W'(MAC_LAT)) begin
                        res_data <= mac_c;
                        state    <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a simple packed-lane MAC model on the mac_* side.
module tb_mac_dot_seq;

    localparam int W = 8, ACC_W = 32, CONF_W = 3, LEN_W = 16, MAC_LAT = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_len = '0;
    logic [1:0]              cmd_mode = '0;
    logic [ACC_W-1:0]        cmd_init = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [4*W-1:0]          in_a = '0;
    logic [W-1:0]            in_b = '0;
    logic                    mac_en, mac_clr;
    logic [W-1:0]            mac_a0, mac_a1, mac_a2, mac_a3, mac_b0;
    logic [ACC_W+CONF_W-1:0] mac_cfg;
    logic [ACC_W-1:0]        mac_c;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic [ACC_W-1:0]        res_data;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int rdy_cnt = 0;

    mac_dot_seq #(.W(W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_mode(cmd_mode), .cmd_init(cmd_init),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3), .mac_b0(mac_b0),
        .mac_cfg(mac_cfg), .mac_c(mac_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // MAC model: single = a0*b, dual = 16-bit lanes, quad = 8-bit lanes; latency 1.
    function automatic logic [ACC_W-1:0] mac_prod(input logic [1:0] mode);
        logic [ACC_W-1:0] p0, p1, p2, p3, b;
        b  = ACC_W'(mac_b0);
        p0 = ACC_W'(mac_a0) * b;
        p1 = ACC_W'(mac_a1) * b;
        p2 = ACC_W'(mac_a2) * b;
        p3 = ACC_W'(mac_a3) * b;
        case (mode)
            2'd0:    return p0;
            2'd1:    return p0 + (p1 << 16);
            2'd2:    return p0 + (p1 << 8) + (p2 << 16) + (p3 << 24);
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) mac_c <= '0;
        else if (mac_clr) mac_c <= mac_cfg[ACC_W+CONF_W-1:CONF_W];
        else if (mac_en) mac_c <= mac_c + mac_prod(mac_cfg[1:0]);
    end

    always @(posedge clk) begin
        if (mac_en) en_cnt++;
        if (mac_clr) clr_cnt++;
        if (in_ready) rdy_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [1:0] mode,
                            input logic [ACC_W-1:0] init);
        cmd_len   = len;
        cmd_mode  = mode;
        cmd_init  = init;
        cmd_valid = 1'b1;
        en_cnt    = 0;
        clr_cnt   = 0;
        rdy_cnt   = 0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, busy, in_ready, res_valid, mac_en, mac_clr} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {cmd_ready, busy, in_ready, res_valid, mac_en, mac_clr});
        end
        checks++;
        if ({mac_a0, mac_a1, mac_a2, mac_a3, mac_b0} !== 40'd0) begin
            errors++;
            $display("FAIL reset_operands got %h want 0", {mac_a0, mac_a1, mac_a2, mac_a3, mac_b0});
        end
        checks++;
        if (mac_cfg !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_cfg_res got cfg=%h res=%h want 0", mac_cfg, res_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        send_cmd(3, 2'd0, 32'd0);
        checks++;
        if ({mac_clr, mac_en, in_ready, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL single_prime got %b want 1001", {mac_clr, mac_en, in_ready, busy});
        end
        checks++;
        if (mac_cfg !== {32'd0, 3'b100}) begin
            errors++;
            $display("FAIL single_cfg got %h want %h", mac_cfg, {32'd0, 3'b100});
        end
        tick();
        checks++;
        if ({in_ready, mac_clr} !== 2'b10) begin
            errors++;
            $display("FAIL single_run_entry got %b want 10", {in_ready, mac_clr});
        end
        in_valid = 1'b1;
        in_b = 8'd5;
        in_a = {8'h77, 8'h66, 8'h55, 8'd2};
        tick();
        in_a = {8'h77, 8'h66, 8'h55, 8'd3};
        tick();
        in_a = {8'h77, 8'h66, 8'h55, 8'd4};
        tick();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, mac_en} !== 2'b01 || mac_a0 !== 8'd4) begin
            errors++;
            $display("FAIL single_last_beat got rdy/en=%b a0=%0d want 01 a0=4", {in_ready, mac_en}, mac_a0);
        end
        checks++;
        if ({mac_a1, mac_a2, mac_a3} !== 24'd0) begin
            errors++;
            $display("FAIL single_lane_mask got %h want 0", {mac_a1, mac_a2, mac_a3});
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid got %b want 0", res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd45 || en_cnt != 3) begin
            errors++;
            $display("FAIL single_result got v=%b d=%0d en=%0d want v=1 d=45 en=3", res_valid, res_data, en_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if ({cmd_ready, res_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_return_idle got %b want 100", {cmd_ready, res_valid, busy});
        end
    endtask

    task automatic test_quad();
        send_cmd(1, 2'd2, 32'd100);
        checks++;
        if (mac_cfg !== {32'd100, 3'b110}) begin
            errors++;
            $display("FAIL quad_cfg got %h want %h", mac_cfg, {32'd100, 3'b110});
        end
        tick();
        in_valid = 1'b1;
        in_a = 32'h04030201;
        in_b = 8'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({mac_a3, mac_a2, mac_a1, mac_a0, mac_b0} !== 40'h0403020102) begin
            errors++;
            $display("FAIL quad_lanes got %h want 0403020102", {mac_a3, mac_a2, mac_a1, mac_a0, mac_b0});
        end
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h08060466) begin
            errors++;
            $display("FAIL quad_result got v=%b d=%h want v=1 d=08060466", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        send_cmd(0, 2'd0, 32'd7);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd7) begin
            errors++;
            $display("FAIL len0_result got v=%b d=%0d want v=1 d=7", res_valid, res_data);
        end
        checks++;
        if (clr_cnt != 0 || en_cnt != 0 || rdy_cnt != 0 || mac_clr !== 1'b0) begin
            errors++;
            $display("FAIL len0_no_mac got clr=%0d en=%0d rdy=%0d want 0 0 0", clr_cnt, en_cnt, rdy_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_gapped();
        logic [7:0] va [7] = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd4};
        logic       pv [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] last_a = 8'd0;
        send_cmd(4, 2'd0, 32'd10);
        tick();
        for (int i = 0; i < 7; i++) begin
            in_valid = pv[i];
            in_a = {24'hABCDEF, pv[i] ? va[i] : 8'hEE};
            in_b = pv[i] ? 8'd3 : 8'h11;
            tick();
            if (pv[i]) last_a = va[i];
            checks++;
            if (mac_en !== pv[i] || mac_a0 !== last_a || mac_b0 !== 8'd3 || in_ready !== (i != 6)) begin
                errors++;
                $display("FAIL gapped_step%0d got en=%b a0=%0d b0=%0d rdy=%b want en=%b a0=%0d b0=3 rdy=%b",
                         i, mac_en, mac_a0, mac_b0, in_ready, pv[i], last_a, (i != 6));
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd40 || en_cnt != 4) begin
            errors++;
            $display("FAIL gapped_result got v=%b d=%0d en=%0d want v=1 d=40 en=4", res_valid, res_data, en_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send_cmd(1, 2'd0, 32'd0);
        tick();
        in_valid = 1'b1;
        in_a = {24'd0, 8'd9};
        in_b = 8'd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_len = 0;
        cmd_init = 32'd5;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({res_valid, cmd_ready, in_ready} !== 3'b100 || res_data !== 32'd81) begin
                errors++;
                $display("FAIL bp_hold%0d got v/cr/ir=%b d=%0d want 100 d=81",
                         i, {res_valid, cmd_ready, in_ready}, res_data);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if ({cmd_ready, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_after_handshake got %b want 10", {cmd_ready, res_valid});
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd5) begin
            errors++;
            $display("FAIL bp_next_cmd got v=%b d=%0d want v=1 d=5", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        send_cmd(5, 2'd0, 32'd0);
        tick();
        in_valid = 1'b1;
        in_a = {24'd0, 8'd1};
        in_b = 8'd1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy, in_ready, res_valid, mac_en, mac_clr} !== 6'b100000) begin
            errors++;
            $display("FAIL midrun_reset got %b want 100000",
                     {cmd_ready, busy, in_ready, res_valid, mac_en, mac_clr});
        end
        tick();
        checks++;
        if (clr_cnt != 1 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL midrun_no_clr got clr=%0d res=%0d want clr=1 res=0", clr_cnt, res_data);
        end
        send_cmd(1, 2'd0, 32'd3);
        tick();
        in_valid = 1'b1;
        in_a = {24'd0, 8'd4};
        in_b = 8'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd23 || en_cnt != 1) begin
            errors++;
            $display("FAIL midrun_recover got v=%b d=%0d en=%0d want v=1 d=23 en=1", res_valid, res_data, en_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_quad();
        test_len_zero();
        test_gapped();
        test_backpressure();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
